// File: rtl/hazard_forward_unit.sv
// Operand forwarding (youngest-stage-first) plus load-use stall FSM for the EX stage.
// Optional stall-cycle counter is enabled by defining HFU_STALL_CNT_EN.
module hazard_forward_unit #(
    parameter int AW       = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_STG  = 2,
    parameter int SELW     = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*AW-1:0]     rs_idex,
    input  logic [NUM_SRC*AW-1:0]     rs_ifid,
    input  logic [NUM_SRC-1:0]        rs_vld_ifid,
    input  logic [NUM_STG*AW-1:0]     rd_stg,
    input  logic [NUM_STG-1:0]        wb_stg,
    input  logic [AW-1:0]             rd_idex,
    input  logic                      memrd_idex,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic [31:0]               stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    logic [NUM_SRC*SELW-1:0] fwd_sel_d;
    logic                    src_hit;
    logic                    haz;
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    stall_d;

    // Stages are scanned oldest to youngest so the youngest match is written last.
    always_comb begin
        fwd_sel_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = NUM_STG; k > 0; k--) begin
                if (wb_stg[k-1] &&
                    (rd_stg[(k-1)*AW +: AW] != '0) &&
                    (rd_stg[(k-1)*AW +: AW] == rs_idex[i*AW +: AW])) begin
                    fwd_sel_d[i*SELW +: SELW] = SELW'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel <= '0;
        end else begin
            fwd_sel <= fwd_sel_d;
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_hit = src_hit | (rs_vld_ifid[i] && (rs_ifid[i*AW +: AW] == rd_idex));
        end
        haz = memrd_idex && (rd_idex != '0) && src_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first stall cycle is spent in IDLE, so STALL only covers LOAD_LAT-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        case (state_q)
            IDLE: begin
                stall_d = haz;
                if (haz && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = 4'(LOAD_LAT - 2);
                end
            end
            STALL: begin
                stall_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by reset so the Mealy path cannot stall while reset is held.
    assign stall  = rst & stall_d;
    assign bubble = stall;

`ifdef HFU_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
